// File: rtl/dsadc_seq.sv
// Conversion sequencer for a 3.5-digit dual-slope ADC: auto-zero / integrate /
// de-integrate phase control, BCD result counting and latching, and digit scan-out.
module dsadc_seq #(
  parameter int unsigned AZ_LEN    = 4000,
  parameter int unsigned INT_LEN   = 4000,
  parameter int unsigned DEINT_LEN = 4000,
  parameter int unsigned UR_LIMIT  = 180,
  parameter int unsigned SCAN_LEN  = 16
) (
  input  logic        CP,
  input  logic        RB,
  input  logic        CMP,
  input  logic        DU,
  output logic        AZ,
  output logic        INTG,
  output logic        DEINT,
  output logic        EOC,
  output logic [15:0] DATA,
  output logic        POL,
  output logic        OR,
  output logic        UR,
  output logic [3:0]  DS,
  output logic [3:0]  Q
);

  localparam int unsigned PH_W   = 12;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SCAN_W = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;

  localparam logic [PH_W-1:0]   AZ_LAST   = PH_W'(AZ_LEN - 1);
  localparam logic [PH_W-1:0]   INT_LAST  = PH_W'(INT_LEN - 1);
  localparam logic [PH_W-1:0]   DEI_LAST  = PH_W'(DEINT_LEN - 1);
  localparam logic [PH_W-1:0]   UR_BIN    = PH_W'(UR_LIMIT);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_LEN - 1);

  typedef enum logic [1:0] {
    S_AZ  = 2'd0,
    S_INT = 2'd1,
    S_DEI = 2'd2,
    S_EOC = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PH_W-1:0]     r_phase;
  logic [BCD_W-1:0]    r_bcd;
  logic                r_pol_cap;
  logic                r_force_or;
  logic [BCD_W-1:0]    r_data;
  logic                r_pol;
  logic                r_or;
  logic                r_ur;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [3:0]          r_ds;

  logic                w_ph_clr;
  logic                w_ph_inc;
  logic                w_bcd_clr;
  logic                w_bcd_inc;
  logic                w_pol_cap;
  logic                w_force_or_set;
  logic                w_force_or_clr;
  logic                w_latch;
  logic [PH_W-1:0]     w_bin;
  logic                w_or;
  logic                w_ur;
  logic [3:0]          w_q;

  // Decimal increment across four BCD decades, rippling carry from units upward.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Phase state register.
  always_ff @(posedge CP or negedge RB) begin
    if (!RB) begin
      r_state <= S_AZ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt    = r_state;
    w_ph_clr       = 1'b0;
    w_ph_inc       = 1'b0;
    w_bcd_clr      = 1'b0;
    w_bcd_inc      = 1'b0;
    w_pol_cap      = 1'b0;
    w_force_or_set = 1'b0;
    w_force_or_clr = 1'b0;
    w_latch        = 1'b0;
    case (r_state)
      S_AZ: begin
        if (r_phase == AZ_LAST) begin
          w_state_nxt = S_INT;
          w_ph_clr    = 1'b1;
        end else begin
          w_ph_inc    = 1'b1;
        end
      end
      S_INT: begin
        if (r_phase == INT_LAST) begin
          w_state_nxt = S_DEI;
          w_ph_clr    = 1'b1;
          w_bcd_clr   = 1'b1;
          w_pol_cap   = 1'b1;
        end else begin
          w_ph_inc    = 1'b1;
        end
      end
      S_DEI: begin
        // A zero crossing takes priority over the timeout on the same cycle.
        if (!CMP) begin
          w_state_nxt = S_EOC;
        end else begin
          w_bcd_inc = 1'b1;
          w_ph_inc  = 1'b1;
          if (r_phase == DEI_LAST) begin
            w_state_nxt    = S_EOC;
            w_force_or_set = 1'b1;
          end
        end
      end
      S_EOC: begin
        w_state_nxt    = S_AZ;
        w_ph_clr       = 1'b1;
        w_bcd_clr      = 1'b1;
        w_force_or_clr = 1'b1;
        w_latch        = DU;
      end
      default: begin
        w_state_nxt = S_AZ;
        w_ph_clr    = 1'b1;
        w_bcd_clr   = 1'b1;
      end
    endcase
  end

  // Phase counter.
  always_ff @(posedge CP or negedge RB) begin
    if (!RB) begin
      r_phase <= '0;
    end else if (w_ph_clr) begin
      r_phase <= '0;
    end else if (w_ph_inc) begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  // De-integrate BCD counter.
  always_ff @(posedge CP or negedge RB) begin
    if (!RB) begin
      r_bcd <= '0;
    end else if (w_bcd_clr) begin
      r_bcd <= '0;
    end else if (w_bcd_inc) begin
      r_bcd <= bcd_inc(r_bcd);
    end
  end

  // Polarity capture and timeout flag for the conversion in flight.
  always_ff @(posedge CP or negedge RB) begin
    if (!RB) begin
      r_pol_cap  <= 1'b0;
      r_force_or <= 1'b0;
    end else begin
      if (w_pol_cap) begin
        r_pol_cap <= CMP;
      end
      if (w_force_or_clr) begin
        r_force_or <= 1'b0;
      end else if (w_force_or_set) begin
        r_force_or <= 1'b1;
      end
    end
  end

  assign w_bin = PH_W'(r_bcd[15:12]) * PH_W'(1000)
               + PH_W'(r_bcd[11:8])  * PH_W'(100)
               + PH_W'(r_bcd[7:4])   * PH_W'(10)
               + PH_W'(r_bcd[3:0]);
  assign w_or  = (r_bcd[15:12] >= 4'd2) | r_force_or;
  assign w_ur  = (w_bin < UR_BIN) & ~w_or;

  // Result latch, updated only on an EOC cycle with display update enabled.
  always_ff @(posedge CP or negedge RB) begin
    if (!RB) begin
      r_data <= '0;
      r_pol  <= 1'b0;
      r_or   <= 1'b0;
      r_ur   <= 1'b0;
    end else if (w_latch) begin
      r_data <= r_bcd;
      r_pol  <= r_pol_cap;
      r_or   <= w_or;
      r_ur   <= w_ur;
    end
  end

  // Free-running digit scan.
  always_ff @(posedge CP or negedge RB) begin
    if (!RB) begin
      r_scan_cnt <= '0;
      r_ds       <= 4'b0001;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_ds       <= {r_ds[2:0], r_ds[3]};
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Selected digit follows DATA immediately, including mid-strobe updates.
  always_comb begin
    w_q = 4'h0;
    case (r_ds)
      4'b0001: w_q = r_data[15:12];
      4'b0010: w_q = r_data[11:8];
      4'b0100: w_q = r_data[7:4];
      4'b1000: w_q = r_data[3:0];
      default: w_q = 4'h0;
    endcase
  end

  assign AZ    = (r_state == S_AZ);
  assign INTG  = (r_state == S_INT);
  assign DEINT = (r_state == S_DEI);
  assign EOC   = (r_state == S_EOC);
  assign DATA  = r_data;
  assign POL   = r_pol;
  assign OR    = r_or;
  assign UR    = r_ur;
  assign DS    = r_ds;
  assign Q     = w_q;

endmodule

// File: doc/dsadc_seq.md
Name: dsadc_seq

Overview:
- Conversion sequencer for the 3.5-digit dual-slope ADC.
- Steps the integrator through three phases in order: auto-zero, signal integrate, reference de-integrate.
- Counts de-integrate clocks into a 4-decade BCD counter. Latches result, polarity, over-range and under-range at end of conversion.
- Scans the latched digits out on a multiplexed BCD bus with one-hot digit strobes, for the display/digit-select logic downstream of the BCD counter chain.

Parameters:
- AZ_LEN, 4000: auto-zero phase length in CP cycles (≥2).
- INT_LEN, 4000: integrate phase length in CP cycles (≥2).
- DEINT_LEN, 4000: de-integrate timeout in CP cycles (≤3999).
- UR_LIMIT, 180: result below this count sets UR.
- SCAN_LEN, 16: CP cycles per digit strobe (≥1).

Ports:
- CP  input  1  clock, rising edge.
- RB  input  1  reset, asynchronous, active-low.
- CMP  input  1  comparator output, synchronous to CP; 1 = integrator not yet returned to zero.
- DU  input  1  display update enable, sampled on the EOC cycle.
- AZ  output  1  auto-zero phase active.
- INTG  output  1  integrate phase active.
- DEINT  output  1  de-integrate phase active.
- EOC  output  1  one-cycle end-of-conversion pulse.
- DATA  output  16  latched BCD result, [15:12] thousands .. [3:0] units.
- POL  output  1  latched polarity, 1 = positive.
- OR  output  1  latched over-range.
- UR  output  1  latched under-range.
- DS  output  4  one-hot digit strobe, DS[0] = DS1 = thousands .. DS[3] = DS4 = units.
- Q  output  4  BCD digit selected by DS.

Behaviour:
- Reset (RB=0, asynchronous):
  - Outputs: AZ=1, INTG=0, DEINT=0, EOC=0, DATA=0, POL=0, OR=0, UR=0, DS=4'b0001, Q=0.
  - Phase counter=0, BCD counter=0, scan counter=0.
  - Asserting reset mid-conversion aborts the conversion with no latch update.
- Phase state machine (states AZ, INT, DEI, EOC). Exactly one of AZ/INTG/DEINT is high in AZ/INT/DEI; all three are low in EOC.
  - AZ: phase counter 0..AZ_LEN-1. At the last count, go to INT and clear the phase counter.
  - INT: INT_LEN cycles. On the last INT cycle, capture CMP into an internal polarity register. Go to DEI with the BCD counter cleared.
  - DEI, each cycle:
    - If CMP=1: BCD counter +1 with decimal carry (units 9→0 carries into tens, and so on up to 3999), and phase counter +1.
    - If CMP=0: zero crossing, stop counting without incrementing this cycle, go to EOC.
    - If the phase counter reaches DEINT_LEN-1 with CMP still 1: timeout. Count that cycle, go to EOC, and set an internal force-OR flag.
    - CMP=0 on the first DEI cycle gives count 0.
  - EOC: EOC=1 for exactly one cycle.
    - If DU=1: DATA←BCD counter; POL←captured polarity; OR←(thousands≥2) or force-OR; UR←(count<UR_LIMIT) and not OR.
    - If DU=0: all latched outputs hold.
    - Next state is AZ with counters cleared. Conversions repeat continuously.
- Conversion period: AZ_LEN + INT_LEN + N + 1 cycles, where N = de-integrate cycles.
- Counter widths: phase counter is 12 bits (covers parameter maximum 4095); BCD counter is 4×4 bits and never exceeds 3999.
- Digit scan: free-running, independent of conversion phase.
  - DS rotates DS1→DS2→DS3→DS4→DS1, advancing every SCAN_LEN cycles.
  - Q is combinational from DS and DATA, e.g. DS1 → DATA[15:12].
  - A DATA update mid-strobe appears on Q immediately; the scan does not restart.
- Simultaneous timeout and CMP=0 on the same DEI cycle: zero crossing wins, with no count and no force-OR.

Test Plan (overrides AZ_LEN=8, INT_LEN=8, DEINT_LEN=3000, SCAN_LEN=2):
- Reset then release: AZ=1 for 8 cycles, INTG=1 for 8 cycles, then DEINT=1. Reasserting RB mid-INT returns to AZ=1 and leaves DATA=0.
- CMP=1 on the last INT cycle; CMP held 1 for 1234 DEI cycles then 0; DU=1 → one EOC pulse; DATA=16'h1234, POL=1, OR=0, UR=0; AZ=1 the following cycle.
- CMP=0 on the last INT cycle; de-integrate count 57; DU=1 → DATA=16'h0057, POL=0, UR=1. Next conversion with DU=0 and count 500 → DATA still 16'h0057.
- CMP held 1 through DEI → timeout after 3000 cycles; DATA=16'h3000, OR=1, UR=0. A separate count of 2100 → DATA=16'h2100, OR=1.
- Carry chain: count 999 then 1000, verify BCD 16'h0999 then 16'h1000. CMP=0 on the first DEI cycle → DATA=0, UR=1.
- With DATA=16'h1234: DS sequence 0001,0010,0100,1000 each lasting 2 cycles, Q=1,2,3,4, then wraps to DS=0001.
